// File: rtl/minbd_side_buffer.sv
// minbd_side_buffer: show-ahead FIFO side buffer for the MinBD deflection router.
// Holds flits pulled out of the deflection path. The head flit is offered to the
// downstream 4:1 flit select mux. When the head has waited too long without a
// grant, the buffer asks for re-injection priority through o_redirect_req.
//
// Build option: define MINBD_SIDEBUF_REDIRECT_EN to include the head-wait state
// machine. When it is undefined, o_redirect_req is tied low and the FIFO
// behaviour does not change.
module minbd_side_buffer #(
  parameter int FLIT_W       = 64,
  parameter int DEPTH        = 4,
  parameter int REDIR_THRESH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_wr_valid,
  input  logic [FLIT_W-1:0]            i_wr_flit,
  output logic                         o_wr_ready,
  output logic                         o_rd_valid,
  output logic [FLIT_W-1:0]            o_rd_flit,
  input  logic                         i_rd_grant,
  output logic                         o_redirect_req,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [FLIT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_next;

  // Status flags come only from registered state. A pop in the same cycle
  // cannot reopen a full buffer, because there is no path from rd_grant to wr_ready.
  assign o_wr_ready  = (r_count != CNT_W'(DEPTH));
  assign o_rd_valid  = (r_count != '0);
  assign o_occupancy = r_count;
  assign o_rd_flit   = r_mem[r_rd_ptr];

  assign w_push = i_wr_valid && o_wr_ready;
  assign w_pop  = i_rd_grant && o_rd_valid;

  // Next occupancy. A push and a pop in the same cycle leave the count unchanged.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Storage write. The array is not cleared on reset, so its contents are stale
  // until they are overwritten.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= i_wr_flit;
    end
  end

  // Pointers and count. DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
    end
  end

`ifdef MINBD_SIDEBUF_REDIRECT_EN

  // state    | meaning
  // ---------+----------------------------------------------------------
  // IDLE     | buffer empty, wait counter cleared
  // HOLD     | head presented, counting cycles it goes un-granted
  // REDIRECT | head waited REDIR_THRESH cycles; request re-injection
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam int WAIT_W = $clog2(REDIR_THRESH+1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_next;

  // Head-wait transitions. The move to REDIRECT happens on the same edge where
  // the count reaches REDIR_THRESH, so the request shows exactly REDIR_THRESH
  // cycles after the head first appears.
  always_comb begin
    w_state_next = r_state;
    w_wait_next  = r_wait_cnt;
    case (r_state)
      ST_IDLE: begin
        w_wait_next = '0;
        if (w_push) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_pop) begin
          w_wait_next  = '0;
          w_state_next = (w_count_next != '0) ? ST_HOLD : ST_IDLE;
        end else if (o_rd_valid) begin
          if (r_wait_cnt == WAIT_W'(REDIR_THRESH-1)) begin
            w_wait_next  = WAIT_W'(REDIR_THRESH);
            w_state_next = ST_REDIRECT;
          end else begin
            w_wait_next  = r_wait_cnt + WAIT_W'(1);
          end
        end
      end
      ST_REDIRECT: begin
        if (w_pop) begin
          w_wait_next  = '0;
          w_state_next = (w_count_next != '0) ? ST_HOLD : ST_IDLE;
        end
      end
      default: begin
        w_wait_next  = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_next;
    end
  end

  assign o_redirect_req = (r_state == ST_REDIRECT);

`else

  assign o_redirect_req = 1'b0;

`endif

endmodule

// File: tb/tb_minbd_side_buffer.sv
// Self-checking bench for minbd_side_buffer, built around a queue-based reference model.
module tb_minbd_side_buffer;

  localparam int FLIT_W       = 64;
  localparam int DEPTH        = 4;
  localparam int REDIR_THRESH = 8;
  localparam int CNT_W        = $clog2(DEPTH+1);

`ifdef MINBD_SIDEBUF_REDIRECT_EN
  localparam bit REDIR_ON = 1'b1;
`else
  localparam bit REDIR_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_valid;
  logic [FLIT_W-1:0] wr_flit;
  logic              wr_ready;
  logic              rd_valid;
  logic [FLIT_W-1:0] rd_flit;
  logic              rd_grant;
  logic              redirect_req;
  logic [CNT_W-1:0]  occupancy;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: queued flits, plus how many cycles the current head has sat un-granted
  logic [FLIT_W-1:0] q[$];
  int                age;

  minbd_side_buffer #(
    .FLIT_W(FLIT_W), .DEPTH(DEPTH), .REDIR_THRESH(REDIR_THRESH)
  ) dut (
    .clk(clk), .reset(reset),
    .i_wr_valid(wr_valid), .i_wr_flit(wr_flit), .o_wr_ready(wr_ready),
    .o_rd_valid(rd_valid), .o_rd_flit(rd_flit), .i_rd_grant(rd_grant),
    .o_redirect_req(redirect_req), .o_occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the model across the edge, then settle 1 time unit.
  task automatic drive(input logic rst, input logic wv, input logic [FLIT_W-1:0] wf,
                       input logic rg);
    bit push_ok, pop_ok;
    reset = rst; wr_valid = wv; wr_flit = wf; rd_grant = rg;
    push_ok = wv && (q.size() < DEPTH);
    pop_ok  = rg && (q.size() > 0);
    @(posedge clk);
    if (rst) begin
      q.delete();
      age = 0;
    end else begin
      if (pop_ok) begin
        void'(q.pop_front());
        age = 0;
      end else if (q.size() > 0 && age < 1000) begin
        age++;
      end
      if (push_ok) q.push_back(wf);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0);
      n_total++;
      if (rd_valid !== 1'b0 || wr_ready !== 1'b1 || occupancy !== '0 || redirect_req !== 1'b0)
        $display("FAIL reset_idle cyc%0d: rd_valid=%b wr_ready=%b occ=%0d redir=%b, required 0 1 0 0",
                 i, rd_valid, wr_ready, occupancy, redirect_req);
      else n_pass++;
    end
  endtask

  task automatic test_fill_drain();
    logic [FLIT_W-1:0] exp_f;
    drive(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, FLIT_W'(8'hA1 + i), 1'b0);
    n_total++;
    if (occupancy !== CNT_W'(4) || wr_ready !== 1'b0)
      $display("FAIL fill_full: occ=%0d wr_ready=%b, required 4 0", occupancy, wr_ready);
    else n_pass++;
    drive(1'b0, 1'b1, FLIT_W'(8'hA5), 1'b0);
    n_total++;
    if (occupancy !== CNT_W'(4))
      $display("FAIL push_when_full: occ=%0d, required 4", occupancy);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp_f = FLIT_W'(8'hA1 + i);
      n_total++;
      if (rd_valid !== 1'b1 || rd_flit !== exp_f)
        $display("FAIL drain_order %0d: rd_valid=%b flit=%h, required 1 %h", i, rd_valid, rd_flit, exp_f);
      else n_pass++;
      drive(1'b0, 1'b0, '0, 1'b1);
    end
    n_total++;
    if (rd_valid !== 1'b0 || occupancy !== '0)
      $display("FAIL drain_empty: rd_valid=%b occ=%0d, required 0 0", rd_valid, occupancy);
    else n_pass++;
  endtask

  task automatic test_full_push_pop();
    drive(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, FLIT_W'(8'h11 + i), 1'b0);
    drive(1'b0, 1'b1, FLIT_W'(8'hB0), 1'b1);
    n_total++;
    if (occupancy !== CNT_W'(3) || rd_flit !== FLIT_W'(8'h12))
      $display("FAIL full_push_pop: occ=%0d head=%h, required 3 12", occupancy, rd_flit);
    else n_pass++;
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, FLIT_W'(8'hE5), 1'b1);
    n_total++;
    if (occupancy !== CNT_W'(2) || rd_flit !== FLIT_W'(8'h14))
      $display("FAIL mid_push_pop: occ=%0d head=%h, required 2 14", occupancy, rd_flit);
    else n_pass++;
    drive(1'b0, 1'b0, '0, 1'b1);
    n_total++;
    if (occupancy !== CNT_W'(1) || rd_flit !== FLIT_W'(8'hE5))
      $display("FAIL order_after_push_pop: occ=%0d head=%h, required 1 e5", occupancy, rd_flit);
    else n_pass++;
    drive(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_wrap();
    int pushed = 0, popped = 0;
    bit wv, rg;
    drive(1'b1, 1'b0, '0, 1'b0);
    for (int it = 0; it < 200 && popped < 10; it++) begin
      wv = (pushed < 10) && (q.size() < 3);
      rg = (q.size() >= 1) && (q.size() == 3 || pushed == 10 || $urandom_range(0, 1) == 1);
      if (rg) begin
        n_total++;
        if (rd_valid !== 1'b1 || rd_flit !== FLIT_W'(popped))
          $display("FAIL wrap_order %0d: rd_valid=%b flit=%h, required 1 %h",
                   popped, rd_valid, rd_flit, FLIT_W'(popped));
        else n_pass++;
        popped++;
      end
      drive(1'b0, wv, FLIT_W'(pushed), rg);
      if (wv) pushed++;
    end
    n_total++;
    if (popped != 10 || occupancy !== '0)
      $display("FAIL wrap_complete: popped=%0d occ=%0d, required 10 0", popped, occupancy);
    else n_pass++;
  endtask

  task automatic test_redirect();
    logic exp_r;
    drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, FLIT_W'(8'hC1), 1'b0);
    for (int k = 0; k <= REDIR_THRESH + 3; k++) begin
      exp_r = REDIR_ON && (k >= REDIR_THRESH);
      n_total++;
      if (redirect_req !== exp_r || rd_valid !== 1'b1)
        $display("FAIL redirect_wait k=%0d: redir=%b rd_valid=%b, required %b 1",
                 k, redirect_req, rd_valid, exp_r);
      else n_pass++;
      drive(1'b0, 1'b0, '0, 1'b0);
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    n_total++;
    if (redirect_req !== 1'b0 || rd_valid !== 1'b0)
      $display("FAIL redirect_clear: redir=%b rd_valid=%b, required 0 0", redirect_req, rd_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, FLIT_W'(8'h71 + i), 1'b0);
    for (int i = 0; i < REDIR_THRESH; i++) drive(1'b0, 1'b0, '0, 1'b0);
    n_total++;
    if (redirect_req !== REDIR_ON || occupancy !== CNT_W'(3))
      $display("FAIL pre_reset: redir=%b occ=%0d, required %b 3", redirect_req, occupancy, REDIR_ON);
    else n_pass++;
    drive(1'b1, 1'b0, '0, 1'b0);
    n_total++;
    if (occupancy !== '0 || rd_valid !== 1'b0 || redirect_req !== 1'b0)
      $display("FAIL mid_reset: occ=%0d rd_valid=%b redir=%b, required 0 0 0",
               occupancy, rd_valid, redirect_req);
    else n_pass++;
    drive(1'b0, 1'b1, FLIT_W'(8'hD1), 1'b0);
    n_total++;
    if (rd_valid !== 1'b1 || rd_flit !== FLIT_W'(8'hD1) || occupancy !== CNT_W'(1))
      $display("FAIL post_reset_push: rd_valid=%b flit=%h occ=%0d, required 1 d1 1",
               rd_valid, rd_flit, occupancy);
    else n_pass++;
  endtask

  task automatic test_random();
    logic rst, wv, rg, exp_r;
    logic [FLIT_W-1:0] wf;
    drive(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      wv  = ($urandom_range(0, 99) < 45);
      rg  = ($urandom_range(0, 99) < ((i % 200) < 100 ? 40 : 8));
      wf  = {$urandom, $urandom};
      drive(rst, wv, wf, rg);
      exp_r = REDIR_ON && (q.size() > 0) && (age >= REDIR_THRESH);
      n_total++;
      if (occupancy !== CNT_W'(q.size()) || rd_valid !== (q.size() > 0) ||
          wr_ready !== (q.size() < DEPTH) || redirect_req !== exp_r ||
          (q.size() > 0 && rd_flit !== q[0]))
        $display("FAIL random cyc%0d: occ=%0d rd_valid=%b wr_ready=%b redir=%b flit=%h, required occ=%0d redir=%b head=%h",
                 i, occupancy, rd_valid, wr_ready, redirect_req, rd_flit,
                 q.size(), exp_r, (q.size() > 0) ? q[0] : '0);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_flit = '0; rd_grant = 1'b0; age = 0;
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_wrap();
    test_redirect();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
